// File: rtl/regfile_multiport.sv
// Multi-port integer register file with priority writes,
// optional write-to-read bypass and a sequential clear engine.
module regfile_multiport #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_RD_PORTS  = 2,
  parameter int NUM_WR_PORTS  = 1,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_WR_PORTS-1:0]              wr_en,
  input  logic [NUM_WR_PORTS*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]    wr_data,
  input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_data,
  input  logic                                 clr_req,
  output logic                                 clr_busy,
  output logic                                 clr_done,
  output logic                                 wr_conflict
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int IW =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic            clr_last;
  logic            conflict;
  logic [NUM_WR_PORTS-1:0] acc;
  logic [DW-1:0]   regs [NUM_REGS];

  function automatic logic in_range(
    input logic [AW-1:0] a
  );
    return {1'b0, a} < NREGS;
  endfunction

  function automatic logic is_zero(
    input logic [AW-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign clr_busy = (state == CLEAR);
  assign clr_last = (state == CLEAR) && (idx == LAST);

  // Per-port write acceptance; nothing is accepted while clearing.
  always_comb begin
    acc = '0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      acc[p] = wr_en[p] && (state == IDLE)
        && in_range(wr_addr[p*AW +: AW])
        && !is_zero(wr_addr[p*AW +: AW]);
    end
  end

  // Flag two or more accepted writes to one address.
  always_comb begin
    conflict = 1'b0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      for (int q = p + 1; q < NUM_WR_PORTS; q++) begin
        if (acc[p] && acc[q] &&
            wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW])
          conflict = 1'b1;
      end
    end
  end

  // Clear FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
      CLEAR: if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Clear index and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      clr_done    <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      clr_done    <= clr_last;
      wr_conflict <= conflict;
      if (state == CLEAR && !clr_last)
        idx <= idx + 1'b1;
      else
        idx <= '0;
    end
  end

  // Storage: clear one entry per cycle, else commit writes.
  // Later ports are assigned last, so the highest port wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[idx] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (acc[p])
          regs[wr_addr[p*AW +: IW]] <= wr_data[p*DW +: DW];
      end
    end
  end

  // Combinational read ports with optional bypass.
  always_comb begin : rd_mux
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    rd_data = '0;
    a = '0;
    v = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      a = rd_addr[r*AW +: AW];
      v = '0;
      if (rst && in_range(a) && !is_zero(a)) begin
        v = regs[a[IW-1:0]];
        if (BYPASS != 0) begin
          for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (acc[p] && wr_addr[p*AW +: AW] == a)
              v = wr_data[p*DW +: DW];
          end
        end
      end
      rd_data[r*DW +: DW] = v;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: reference model compared
// every cycle plus directed literal expectations.
module tb_regfile_multiport;

  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NWR-1:0]    wr_en   = '0;
  logic [NWR*AW-1:0] wr_addr = '0;
  logic [NWR*DW-1:0] wr_data = '0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data;
  logic clr_req = 1'b0;
  logic clr_busy;
  logic clr_done;
  logic wr_conflict;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m [NR];
  bit m_busy;
  bit m_done;
  bit m_conf;
  int m_pos;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  regfile_multiport #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .NUM_REGS(NR), .NUM_RD_PORTS(NRD),
    .NUM_WR_PORTS(NWR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .wr_conflict(wr_conflict)
  );

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               n, act, exp);
    end
  endtask

  function automatic int wa(input int p);
    return int'(wr_addr[p*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] wd(input int p);
    return wr_data[p*DW +: DW];
  endfunction

  function automatic bit acc(input int p);
    return wr_en[p] && !m_busy && wa(p) < NR
      && wa(p) != 0;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int r);
    int a;
    logic [DW-1:0] v;
    a = int'(rd_addr[r*AW +: AW]);
    if (!rst || a >= NR || a == 0) return '0;
    v = m[a];
    for (int p = 0; p < NWR; p++)
      if (acc(p) && wa(p) == a) v = wd(p);
    return v;
  endfunction

  function automatic logic [DW-1:0] rdv(input int r);
    return rd_data[r*DW +: DW];
  endfunction

  // Reference model: array contents, clear progress, flags.
  always @(posedge clk or negedge rst) begin : model
    bit conf;
    if (!rst) begin
      for (int i = 0; i < NR; i++) m[i] = '0;
      m_busy = 0; m_done = 0; m_conf = 0; m_pos = 0;
    end else begin
      conf = 0;
      if (m_busy) begin
        m[m_pos] = '0;
        m_pos++;
        m_done = (m_pos == NR);
        if (m_done) m_busy = 0;
      end else begin
        m_done = 0;
        for (int p = 0; p < NWR; p++)
          for (int q = p + 1; q < NWR; q++)
            if (acc(p) && acc(q) && wa(p) == wa(q))
              conf = 1;
        for (int p = 0; p < NWR; p++)
          if (acc(p)) m[wa(p)] = wd(p);
        if (clr_req) begin
          m_busy = 1;
          m_pos = 0;
        end
      end
      m_conf = conf;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int r = 0; r < NRD; r++)
        chk($sformatf("rd_data%0d", r), rdv(r), exp_rd(r));
      chk("clr_busy", clr_busy, m_busy);
      chk("clr_done", clr_done, m_done);
      chk("wr_conflict", wr_conflict, m_conf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input bit en,
                        input int a,
                        input logic [DW-1:0] d);
    wr_en[p] = en;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int r, input int a);
    rd_addr[r*AW +: AW] = AW'(a);
  endtask

  task automatic wr_off();
    set_wr(0, 0, 0, '0);
    set_wr(1, 0, 0, '0);
  endtask

  initial begin
    int cnt;
    cmp_en = 1'b1;
    // Reset: sweep read addresses in and out of reset.
    tick();
    set_rd(0, 5);
    #2 chk("rst_rd0", rdv(0), 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_conf", wr_conflict, 0);
    for (int a = 0; a < NR; a += 2) begin
      set_rd(0, a); set_rd(1, a + 1); tick();
    end
    rst = 1'b1;
    for (int a = 0; a < NR; a += 2) begin
      set_rd(0, a); set_rd(1, a + 1); tick();
    end

    // Same-cycle bypass then stored value.
    set_wr(0, 1, 5, 32'hDEADBEEF);
    set_rd(0, 5);
    #2 chk("bypass_x5", rdv(0), 32'hDEADBEEF);
    tick(); wr_off();
    #2 chk("stored_x5", rdv(0), 32'hDEADBEEF);

    // Two ports write x7: port 1 wins, conflict flagged.
    tick();
    set_wr(0, 1, 7, 32'h11);
    set_wr(1, 1, 7, 32'h22);
    set_rd(1, 7);
    #2 chk("bypass_x7", rdv(1), 32'h22);
    tick(); wr_off();
    #2 chk("conf_set", wr_conflict, 1);
    chk("stored_x7", rdv(1), 32'h22);
    tick();
    #2 chk("conf_clr", wr_conflict, 0);

    // x0 and out-of-range writes are dropped.
    set_wr(0, 1, 0, 32'h99);
    set_wr(1, 1, 40, 32'h77);
    set_rd(0, 0); set_rd(1, 40);
    #2 chk("x0_byp", rdv(0), 0);
    chk("oor_byp", rdv(1), 0);
    tick(); wr_off();
    set_rd(1, 8);
    #2 chk("x0_read", rdv(0), 0);
    chk("x8_alias", rdv(1), 0);
    chk("drop_conf", wr_conflict, 0);

    // Fill, clear, and drop writes while busy.
    for (int i = 1; i < NR; i++) begin
      set_wr(0, 1, i, DW'(i)); set_rd(0, i); tick();
    end
    wr_off();
    set_rd(0, 31);
    #2 chk("fill_x31", rdv(0), 31);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    set_wr(0, 1, 9, 32'hAB);
    set_wr(1, 1, 10, 32'hCD);
    set_rd(0, 9); set_rd(1, 10);
    cnt = 0;
    while (clr_busy && cnt < 100) begin
      cnt++; tick();
    end
    wr_off();
    chk("busy_cycles", cnt, NR);
    chk("done_pulse", clr_done, 1);
    #2 chk("busy_x9", rdv(0), 0);
    chk("busy_x10", rdv(1), 0);
    tick();
    chk("done_low", clr_done, 0);

    // Reset in the middle of a clear.
    for (int i = 1; i < NR; i++) begin
      set_wr(0, 1, i, DW'(i + 100)); tick();
    end
    wr_off();
    set_rd(0, 31); set_rd(1, 20);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (10) tick();
    #2 chk("pre_rst_x20", rdv(1), 120);
    rst = 1'b0;
    #1 chk("mid_rst_rd", rdv(0), 0);
    chk("mid_rst_busy", clr_busy, 0);
    chk("mid_rst_done", clr_done, 0);
    tick(); tick();
    rst = 1'b1;
    repeat (40) begin
      tick();
      chk("no_done", clr_done, 0);
    end
    set_wr(0, 1, 3, 32'h5A);
    set_rd(0, 3);
    tick(); wr_off();
    #2 chk("x3_after_rst", rdv(0), 32'h5A);
    tick();

    // Random 2R/2W traffic with occasional clears.
    repeat (4000) begin
      for (int p = 0; p < NWR; p++)
        set_wr(p, 1'($urandom_range(0, 1)),
               $urandom_range(0, 39), $urandom);
      for (int r = 0; r < NRD; r++)
        set_rd(r, $urandom_range(0, 39));
      clr_req = ($urandom_range(0, 149) == 0);
      tick();
    end
    clr_req = 1'b0;
    wr_off();
    repeat (40) tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
